// File: rtl/regfile_sb.sv
// Multi-ported register file with a per-register pending scoreboard (x0 hardwired to zero).
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         pend_cnt
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_pend;
    logic [AW:0]     r_pend_cnt;

    logic [NREG-1:0] w_pend_next;
    logic [AW:0]     w_cnt_next;

    // Issue is applied after the write-clear so it wins on a same-address collision;
    // flush overrides everything.
    always_comb begin
        w_pend_next = r_pend;
        for (int i = 1; i < NREG; i++) begin
            if ((wa_en && wa_addr == AW'(i)) || (wb_en && wb_addr == AW'(i)))
                w_pend_next[i] = 1'b0;
            if (iss_en && iss_addr == AW'(i))
                w_pend_next[i] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
        if (flush)
            w_pend_next = '0;
    end

    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < NREG; i++)
            w_cnt_next = w_cnt_next + (AW+1)'(w_pend_next[i]);
    end

    // Port B is written last so it takes precedence when both ports hit the same register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (wa_en && wa_addr != '0)
                r_regs[wa_addr] <= wa_data;
            if (wb_en && wb_addr != '0)
                r_regs[wb_addr] <= wb_data;
            r_pend     <= w_pend_next;
            r_pend_cnt <= w_cnt_next;
        end
    end

    assign pend_cnt = r_pend_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_rd
            logic [AW-1:0] w_addr;
            assign w_addr = rd_addr[gi*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
            logic w_hit_a;
            logic w_hit_b;
            assign w_hit_a = wa_en && (wa_addr == w_addr) && (w_addr != '0);
            assign w_hit_b = wb_en && (wb_addr == w_addr) && (w_addr != '0);
            assign rd_data[gi*XLEN +: XLEN] = w_hit_b ? wb_data :
                                              w_hit_a ? wa_data : r_regs[w_addr];
            assign rd_busy[gi] = (w_hit_a || w_hit_b) ?
                                 (iss_en && iss_addr == w_addr) : r_pend[w_addr];
`else
            assign rd_data[gi*XLEN +: XLEN] = r_regs[w_addr];
            assign rd_busy[gi]              = r_pend[w_addr];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against an array-level model, plus directed literal checks.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = $clog2(NREG);

    logic                clk = 0;
    logic                rst;
    logic                wa_en, wb_en, iss_en, flush;
    logic [AW-1:0]       wa_addr, wb_addr, iss_addr;
    logic [XLEN-1:0]     wa_data, wb_data;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic [AW:0]         pend_cnt;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    // Reference model: plain arrays updated from the architectural rules.
    logic [XLEN-1:0] m_reg  [NREG];
    bit              m_pend [NREG];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (flush)                          m_pend[i] = 0;
                else if (iss_en && iss_addr == i)   m_pend[i] = 1;
                else if ((wa_en && wa_addr == i) || (wb_en && wb_addr == i)) m_pend[i] = 0;
            end
            if (wa_en && wa_addr != 0) m_reg[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
        end
    end

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    // Single per-cycle compare against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < NRP; k++) begin
                logic [AW-1:0]   a;
                logic [XLEN-1:0] ed;
                logic            eb;
                a  = rd_addr[k*AW +: AW];
                ed = m_reg[a];
                eb = m_pend[a];
`ifdef REGFILE_SB_BYPASS_EN
                if (a != 0 && ((wb_en && wb_addr == a) || (wa_en && wa_addr == a))) begin
                    ed = (wb_en && wb_addr == a) ? wb_data : wa_data;
                    eb = iss_en && iss_addr == a;
                end
`endif
                n_checks++;
                if (rd_data[k*XLEN +: XLEN] !== ed) begin
                    n_fail++;
                    $display("FAIL model_rd_data port=%0d addr=%0d act=%h exp=%h t=%0t",
                             k, a, rd_data[k*XLEN +: XLEN], ed, $time);
                end
                n_checks++;
                if (rd_busy[k] !== eb) begin
                    n_fail++;
                    $display("FAIL model_rd_busy port=%0d addr=%0d act=%b exp=%b t=%0t",
                             k, a, rd_busy[k], eb, $time);
                end
            end
            n_checks++;
            if (pend_cnt !== (AW+1)'(model_cnt())) begin
                n_fail++;
                $display("FAIL model_pend_cnt act=%0d exp=%0d t=%0t", pend_cnt, model_cnt(), $time);
            end
        end
    end

    task automatic idle();
        wa_en = 0; wb_en = 0; iss_en = 0; flush = 0;
        wa_addr = '0; wb_addr = '0; iss_addr = '0;
        wa_data = '0; wb_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Sample port 0 reading register a at the next negedge.
    task automatic rd0(input logic [AW-1:0] a);
        rd_addr[0 +: AW] = a;
        @(negedge clk);
    endtask

    initial begin
        rst = 0;
        idle();
        rd_addr = '0;
        tick();
        check_en = 1;
        rst = 1;
        @(negedge clk);
        chk("post_reset_rd0", rd_data[XLEN-1:0], '0);
        chk("post_reset_rd1", rd_data[2*XLEN-1:XLEN], '0);
        chk("post_reset_busy", XLEN'(rd_busy), '0);
        chk("post_reset_cnt", XLEN'(pend_cnt), '0);

        // Reset clears stored data
        tick();
        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        tick(); idle();
        rd0(5);  chk("x5_written", rd_data[XLEN-1:0], 32'hDEADBEEF);
        tick(); rst = 0; tick(); rst = 1;
        rd0(5);  chk("x5_after_reset", rd_data[XLEN-1:0], '0);
        chk("cnt_after_reset", XLEN'(pend_cnt), '0);

        // Dual-write collision: B wins
        tick();
        wa_en = 1; wa_addr = 7; wa_data = 32'h11;
        wb_en = 1; wb_addr = 7; wb_data = 32'h22;
        tick(); idle();
        rd0(7);  chk("collision_x7", rd_data[XLEN-1:0], 32'h22);

        // x0 is immutable and never pending
        tick();
        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
        iss_en = 1; iss_addr = 0;
        tick(); idle();
        rd0(0);  chk("x0_data", rd_data[XLEN-1:0], '0);
        chk("x0_busy", XLEN'(rd_busy[0]), '0);
        chk("x0_cnt", XLEN'(pend_cnt), '0);

        // Scoreboard set / clear / issue-wins
        tick();
        iss_en = 1; iss_addr = 3;
        tick(); idle();
        rd0(3);  chk("x3_busy_set", XLEN'(rd_busy[0]), 1);
        chk("x3_cnt1", XLEN'(pend_cnt), 1);
        tick();
        wb_en = 1; wb_addr = 3; wb_data = 32'h33;
        tick(); idle();
        rd0(3);  chk("x3_busy_clr", XLEN'(rd_busy[0]), 0);
        chk("x3_cnt0", XLEN'(pend_cnt), 0);
        tick();
        iss_en = 1; iss_addr = 3; wa_en = 1; wa_addr = 3; wa_data = 32'h44;
        tick(); idle();
        rd0(3);  chk("x3_issue_wins", XLEN'(rd_busy[0]), 1);
        chk("x3_data_written", rd_data[XLEN-1:0], 32'h44);
        tick();
        wa_en = 1; wa_addr = 3; wa_data = 32'h44;
        tick(); idle();

        // Flush overrides a simultaneous issue
        iss_en = 1; iss_addr = 1; tick();
        iss_addr = 2; tick();
        iss_addr = 9; tick(); idle();
        @(negedge clk);
        chk("flush_cnt3", XLEN'(pend_cnt), 3);
        tick();
        flush = 1; iss_en = 1; iss_addr = 4;
        tick(); idle();
        rd0(4);  chk("flush_cnt0", XLEN'(pend_cnt), 0);
        chk("flush_x4_busy", XLEN'(rd_busy[0]), 0);

        // Same-cycle write vs read of x10
        tick();
        wa_en = 1; wa_addr = 10; wa_data = 32'h1234;
        tick(); idle();
        wa_en = 1; wa_addr = 10; wa_data = 32'hCAFE;
        rd0(10);
`ifdef REGFILE_SB_BYPASS_EN
        chk("bypass_x10", rd_data[XLEN-1:0], 32'hCAFE);
`else
        chk("no_bypass_x10", rd_data[XLEN-1:0], 32'h1234);
`endif
        tick(); idle();
        rd0(10); chk("x10_after_edge", rd_data[XLEN-1:0], 32'hCAFE);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) != 0);
            wa_en    = $urandom_range(0, 1);
            wb_en    = $urandom_range(0, 1);
            iss_en   = $urandom_range(0, 1);
            flush    = ($urandom_range(0, 29) == 0);
            wa_addr  = AW'($urandom_range(0, NREG-1));
            wb_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, NREG-1));
            iss_addr = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, NREG-1));
            wa_data  = $urandom;
            wb_data  = $urandom;
            for (int k = 0; k < NRP; k++)
                rd_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? wb_addr
                                                                   : AW'($urandom_range(0, NREG-1));
            tick();
        end
        rst = 1;
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
